imem_fetch_responder: RTL

Instruction-memory responder answering the fetch requests issued by the PC/fetch front end. It accepts byte addresses over a valid/ready request channel and reads a word-organised instruction array with a fixed pipeline latency. It returns each instruction, its address and an error flag, in order, over a valid/ready response channel. It sits between the PC/branch-prediction front end and decode, and supports a flush for redirects plus a write port for program loading.

---
 rtl/imem_fetch_responder_if.sv | 26 ++
 rtl/imem_fetch_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response and program-load signal bundle shared by the PC
// front end (master) and the instruction-memory responder (slave).
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: in-order fetch responses with fixed read latency,
// a credit-protected output FIFO, redirect flush and a program-load write port.
module imem_fetch_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_fetch_responder_if.slave bus
);
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam int          FD  = LAT + 1;
    localparam int          PW  = $clog2(FD);
    localparam int          CW  = $clog2(FD + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } payload_t;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          xfer;
    logic          head_valid;
    logic [CW-1:0] outstanding;
    payload_t      in_payload;
    logic          exit_valid;
    payload_t      exit_payload;

    payload_t      fifo_mem [FD];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    payload_t      head;

    logic          unused_wr_lsbs;
    assign unused_wr_lsbs = ^bus.wr_addr[1:0];

    // A transfer in this cycle frees a credit immediately, so a full responder
    // can take a new request in the same cycle the consumer drains one.
    assign xfer          = head_valid && bus.rsp_ready;
    assign bus.req_ready = !reset && !bus.flush && ((outstanding < CW'(FD)) || xfer);
    assign accept        = bus.req_valid && bus.req_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_payload      = '0;
        in_payload.addr = bus.req_addr;
        in_payload.err  = (bus.req_addr[1:0] != 2'b00) ||
                          (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
        in_payload.data = in_payload.err ? NOP : mem[bus.req_addr[AW+1:2]];
    end

    // NOTE: the instruction array carries no reset; program contents survive reset and flush.
    // NOTE: non-blocking writes mean a read accepted on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (bus.wr_addr[31:2] < 30'(DEPTH_WORDS))) begin
            mem[bus.wr_addr[AW+1:2]] <= bus.wr_data;
        end
    end

    // The acceptance edge itself is the first latency stage, so LAT-1 registers follow it.
    if (LAT == 1) begin : g_direct
        assign exit_valid   = accept;
        assign exit_payload = in_payload;
    end else begin : g_pipe
        logic [LAT-2:0] pipe_valid;
        payload_t       pipe [LAT-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pipe_valid <= '0;
            end else if (bus.flush) begin
                pipe_valid <= '0;
            end else begin
                pipe_valid[0] <= accept;
                for (int k = 1; k < LAT - 1; k++) begin
                    pipe_valid[k] <= pipe_valid[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pipe[0] <= in_payload;
            for (int k = 1; k < LAT - 1; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end

        assign exit_valid   = pipe_valid[LAT-2];
        assign exit_payload = pipe[LAT-2];
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pipeline exits always land in the FIFO; with an empty FIFO the entry is the
    // head right after that edge, so the FIFO adds no latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (exit_valid) wr_ptr <= ptr_next(wr_ptr);
            if (xfer)       rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(exit_valid) - CW'(xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (exit_valid) begin
            fifo_mem[wr_ptr] <= exit_payload;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else if (bus.flush) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(xfer);
        end
    end

    // Response fields read as zero whenever nothing is presented.
    assign head          = fifo_mem[rd_ptr];
    assign head_valid    = (count != '0);
    assign bus.rsp_valid = head_valid;
    assign bus.rsp_instr = head_valid ? head.data : '0;
    assign bus.rsp_addr  = head_valid ? head.addr : '0;
    assign bus.rsp_err   = head_valid ? head.err  : 1'b0;
endmodule
